// File: rtl/tdm_pkg.sv
// Shared TDM link definitions.
// Used by the receive demux and the transmit-side serialiser.
package tdm_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    HUNT,
    LOCKED
  } state_t;

  function automatic int slot_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Mod-NUM_CH slot counter.
// Priority: clear, then load-to-1, then advance.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int SW     = slot_w(NUM_CH_DEF)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          adv,
  input  logic          load1,
  input  logic          clr,
  output logic [SW-1:0] slot,
  output logic          is_last
);

  localparam logic [SW-1:0] LAST = SW'(NUM_CH - 1);
  localparam logic [SW-1:0] ONE  = SW'(1);

  assign is_last = (slot == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (clr) begin
      slot <= '0;
    end else if (load1) begin
      slot <= ONE;
    end else if (adv) begin
      slot <= is_last ? '0 : slot + ONE;
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// TDM receive demux: locks to frame_sync,
// steers beats to per-channel holding registers.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        din,
  input  logic                     din_valid,
  input  logic                     frame_sync,
  output logic [NUM_CH*DATA_W-1:0] dout,
  output logic [NUM_CH-1:0]        dout_valid,
  output logic                     frame_done,
  output logic                     locked,
  output logic                     sync_err
);

  localparam int SW = slot_w(NUM_CH);

  state_t        state;
  logic [SW-1:0] slot;
  logic          is_last;
  logic          in_lock;
  logic          slot0;
  logic          cap0;
  logic          capn;
  logic          miss;

  assign in_lock = (state == LOCKED);
  assign slot0   = (slot == '0);

  // A synced beat always starts a frame, even mid-frame.
  assign cap0 = din_valid && frame_sync;
  assign capn = din_valid && !frame_sync && in_lock && !slot0;
  assign miss = din_valid && !frame_sync && in_lock && slot0;

  tdm_slot_counter #(
    .NUM_CH (NUM_CH),
    .SW     (SW)
  ) u_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .adv     (capn),
    .load1   (cap0),
    .clr     (miss),
    .slot    (slot),
    .is_last (is_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      dout       <= '0;
      dout_valid <= '0;
      frame_done <= 1'b0;
      locked     <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      dout_valid <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      unique case (1'b1)
        cap0: begin
          dout[0 +: DATA_W] <= din;
          dout_valid[0]     <= 1'b1;
          sync_err          <= in_lock && !slot0;
          state             <= LOCKED;
          locked            <= 1'b1;
        end
        capn: begin
          dout[slot*DATA_W +: DATA_W] <= din;
          dout_valid[slot]            <= 1'b1;
          frame_done                  <= is_last;
        end
        miss: begin
          sync_err <= 1'b1;
          state    <= HUNT;
          locked   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: directed frames plus
// random traffic against a channel-array model.
module tb_tdm_demux;

  localparam int NC = 4;
  localparam int DW = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [DW-1:0]    din = '0;
  logic             din_valid = 1'b0;
  logic             frame_sync = 1'b0;
  logic [NC*DW-1:0] dout;
  logic [NC-1:0]    dout_valid;
  logic             frame_done;
  logic             locked;
  logic             sync_err;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_ch [NC];
  bit            m_lock;
  int            m_pos;
  logic [NC-1:0] e_dv;
  bit            e_fd;
  bit            e_se;

  tdm_demux #(
    .NUM_CH (NC),
    .DATA_W (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .frame_done (frame_done),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [NC*DW-1:0] m_dout();
    logic [NC*DW-1:0] r;
    for (int k = 0; k < NC; k++)
      r[k*DW +: DW] = m_ch[k];
    return r;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < NC; k++) m_ch[k] = '0;
    m_lock = 0;
    m_pos  = 0;
    e_dv   = '0;
    e_fd   = 0;
    e_se   = 0;
  endtask

  task automatic m_beat(input logic [DW-1:0] d,
                        input bit v,
                        input bit fs);
    e_dv = '0;
    e_fd = 0;
    e_se = 0;
    if (!v) return;
    if (fs) begin
      e_se     = m_lock && (m_pos != 0);
      m_ch[0]  = d;
      e_dv[0]  = 1'b1;
      m_pos    = 1;
      m_lock   = 1;
    end else if (m_lock) begin
      if (m_pos == 0) begin
        e_se   = 1;
        m_lock = 0;
      end else begin
        m_ch[m_pos]  = d;
        e_dv[m_pos]  = 1'b1;
        e_fd         = (m_pos == NC - 1);
        m_pos        = (m_pos + 1) % NC;
      end
    end
  endtask

  task automatic step(input logic [DW-1:0] d,
                      input bit v,
                      input bit fs);
    @(negedge clk);
    din        = d;
    din_valid  = v;
    frame_sync = fs;
    @(posedge clk);
    #1;
    m_beat(d, v, fs);
    chk("dout", 64'(dout), 64'(m_dout()));
    chk("dout_valid", 64'(dout_valid), 64'(e_dv));
    chk("frame_done", 64'(frame_done), 64'(e_fd));
    chk("locked", 64'(locked), 64'(m_lock));
    chk("sync_err", 64'(sync_err), 64'(e_se));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(DW'($urandom), 0, 1'($urandom));
  endtask

  initial begin
    int tx;
    bit fs;
    bit v;
    m_reset();
    #12;
    chk("rst_dout", 64'(dout), 64'h0);
    chk("rst_dv", 64'(dout_valid), 64'h0);
    chk("rst_locked", 64'(locked), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: back-to-back frame
    step(8'h11, 1, 1);
    chk("t1_lock", 64'(locked), 64'h1);
    chk("t1_dv0", 64'(dout_valid), 64'h1);
    step(8'h22, 1, 0);
    chk("t1_dv1", 64'(dout_valid), 64'h2);
    step(8'h33, 1, 0);
    chk("t1_dv2", 64'(dout_valid), 64'h4);
    step(8'h44, 1, 0);
    chk("t1_dv3", 64'(dout_valid), 64'h8);
    chk("t1_fd", 64'(frame_done), 64'h1);
    chk("t1_dout", 64'(dout), 64'h44332211);
    idle(1);

    // 2: same frame with gaps
    step(8'h11, 1, 1);
    idle($urandom_range(1, 3));
    step(8'h22, 1, 0);
    idle($urandom_range(1, 3));
    step(8'h33, 1, 0);
    idle($urandom_range(1, 3));
    step(8'h44, 1, 0);
    chk("t2_fd", 64'(frame_done), 64'h1);
    idle(2);
    chk("t2_dout", 64'(dout), 64'h44332211);

    // 3: drop lock, unsynced beats ignored
    step(8'h99, 1, 0);
    chk("t3_err", 64'(sync_err), 64'h1);
    step(8'hAA, 1, 0);
    chk("t3_aa", 64'(dout_valid), 64'h0);
    step(8'hBB, 1, 0);
    chk("t3_bb", 64'(dout_valid), 64'h0);
    step(8'hC1, 1, 1);
    step(8'hC2, 1, 0);
    step(8'hC3, 1, 0);
    step(8'hC4, 1, 0);
    chk("t3_dout", 64'(dout), 64'hC4C3C2C1);

    // 4: early sync realigns
    step(8'h01, 1, 1);
    step(8'h02, 1, 0);
    step(8'h03, 1, 1);
    chk("t4_err", 64'(sync_err), 64'h1);
    chk("t4_lo", 64'(dout[15:0]), 64'h0203);
    step(8'h04, 1, 0);
    chk("t4_ch1", 64'(dout_valid), 64'h2);
    chk("t4_fd", 64'(frame_done), 64'h0);
    chk("t4_dout", 64'(dout), 64'hC4C30403);
    step(8'h05, 1, 0);
    step(8'h06, 1, 0);

    // 5: missing sync after full frame
    step(8'hA1, 1, 1);
    step(8'hA2, 1, 0);
    step(8'hA3, 1, 0);
    step(8'hA4, 1, 0);
    step(8'h55, 1, 0);
    chk("t5_err", 64'(sync_err), 64'h1);
    chk("t5_lock", 64'(locked), 64'h0);
    chk("t5_dv", 64'(dout_valid), 64'h0);
    chk("t5_dout", 64'(dout), 64'hA4A3A2A1);

    // 6: async reset mid-frame
    step(8'h61, 1, 1);
    step(8'h62, 1, 0);
    step(8'h63, 1, 0);
    din_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("t6_dout", 64'(dout), 64'h0);
    chk("t6_dv", 64'(dout_valid), 64'h0);
    chk("t6_fd", 64'(frame_done), 64'h0);
    chk("t6_lock", 64'(locked), 64'h0);
    chk("t6_err", 64'(sync_err), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h77, 1, 0);
    chk("t6_drop", 64'(dout_valid), 64'h0);
    step(8'h88, 1, 1);
    chk("t6_cap", 64'(dout), 64'h88);

    // random traffic with occasional sync faults
    tx = 1;
    for (int i = 0; i < 600; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      fs = (tx == 0);
      if ($urandom_range(0, 15) == 0) fs = !fs;
      step(DW'($urandom), v, fs);
      if (v) tx = fs ? 1 : (tx + 1) % NC;
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receive end of a time-division-multiplexed link: one shared data lane carries NUM_CH channel words in round-robin slots, with frame_sync marking slot 0.
- Block locks to frame_sync, steers each valid beat into its channel's holding register, and pulses per-channel valid strobes.
- Detects loss of alignment and re-hunts.
- Sits behind any mux-based serialiser in the datapath and feeds per-channel consumers.

Parameters:
- NUM_CH, 4, number of channels per frame (>=2)
- DATA_W, 8, width of one channel word

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- din  input  DATA_W  TDM data beat
- din_valid  input  1  din carries a slot beat this cycle
- frame_sync  input  1  qualifies the current valid beat as slot 0; ignored when din_valid=0
- dout  output  NUM_CH*DATA_W  channel holding registers; channel k at bits [k*DATA_W +: DATA_W]
- dout_valid  output  NUM_CH  one-cycle pulse; bit k means channel k was updated
- frame_done  output  1  one-cycle pulse when slot NUM_CH-1 of an aligned frame is captured
- locked  output  1  high in LOCKED state
- sync_err  output  1  one-cycle pulse on an alignment violation

Behaviour:
- Reset (async assert, sync release):
  - dout=0, dout_valid=0, frame_done=0, sync_err=0, locked=0.
  - State=HUNT, slot=0.
- All outputs are registered. A captured beat appears on dout, with its dout_valid bit, 1 cycle after the input cycle.
- Slot counter is $clog2(NUM_CH) bits. It advances only on accepted valid beats and wraps NUM_CH-1 -> 0.
- Cycles with din_valid=0 change nothing. Gaps between beats are legal anywhere.
- HUNT:
  - Valid beats without frame_sync are discarded with no strobe.
  - A valid beat with frame_sync is captured as ch0, sets slot=1, and moves to LOCKED.
  - locked rises in the same cycle dout_valid[0] pulses.
- LOCKED, valid beat, slot!=0, frame_sync=0:
  - Capture into ch[slot] and pulse dout_valid[slot].
  - If slot==NUM_CH-1, also pulse frame_done; slot wraps to 0.
- LOCKED, valid beat, slot==0, frame_sync=1: capture ch0 and set slot=1 (normal frame start).
- LOCKED, valid beat, slot==0, frame_sync=0 (missing sync):
  - Pulse sync_err, discard the beat, go to HUNT, deassert locked.
  - dout keeps its old values.
- LOCKED, valid beat, slot!=0, frame_sync=1 (early sync):
  - Pulse sync_err and realign: capture as ch0, slot=1, stay LOCKED.
  - The truncated frame produces no frame_done.
  - Channels already captured keep their values.
- dout_valid is one-hot or zero every cycle. frame_done implies dout_valid[NUM_CH-1].
- Reset mid-frame: outputs clear immediately. The partial frame is lost and the block resumes in HUNT.

Decomposition:
- Shared package tdm_pkg:
  - state enum {HUNT, LOCKED}
  - slot-width helper function (clog2 of NUM_CH)
  - default NUM_CH and DATA_W constants, shared with the transmit-side mux serialiser
- One sub-module, tdm_slot_counter: mod-NUM_CH counter with advance, load-to-1 and clear inputs, and an is_last flag.
- FSM, capture registers and strobes stay in tdm_demux.

Test Plan:
1. Reset release, then beats 0x11(sync),0x22,0x33,0x44 back-to-back.
   - Required: dout = {0x44,0x33,0x22,0x11}.
   - dout_valid pulses 0001,0010,0100,1000 on consecutive cycles, each 1 cycle after input.
   - frame_done with the last pulse; locked=1 from the first capture.
2. Same frame with din_valid=0 gaps of 1-3 cycles between beats.
   - Required: identical dout, one strobe per beat, no sync_err.
3. Valid beats 0xAA,0xBB without sync while in HUNT, then a synced frame.
   - Required: no dout_valid for 0xAA/0xBB.
   - Capture begins at the synced beat.
4. Locked; frame 0x01(sync),0x02 then 0x03 with frame_sync=1.
   - Required: sync_err pulse; ch0=0x03, ch1=0x02.
   - Next beat 0x04 goes to ch1; no frame_done for the truncated frame.
5. Locked; a full frame completes, then the next valid beat 0x55 has no sync.
   - Required: sync_err pulse, locked falls, no dout_valid, dout unchanged.
6. rst_n pulsed low asynchronously mid-frame after slot 2.
   - Required: all outputs 0 immediately.
   - After release, a beat without sync is discarded and a beat with sync is captured as ch0.
